sram_readback: RTL and testbench
================================

# sram_readback

Drains the result SRAM (bank A) after a matrix run and streams its contents to the host one element at a time over a valid/ready interface. It is the read-side counterpart of the accelerator write-out path. That path writes rows of ARRAY_SIZE packed OUTPUT_DATA_WIDTH-bit results at 6-bit addresses; this block reads those rows back and serializes them lane by lane. It sits between the result SRAM read port and the host/testbench interface and is typically kicked by the accelerator's done pulse.

## Interface
Parameters:
- ARRAY_SIZE, 8, elements per SRAM row
- OUTPUT_DATA_WIDTH, 16, bits per element
- ADDR_WIDTH, 6, SRAM address width
- MAX_ROWS, 64, maximum rows per drain (2**ADDR_WIDTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- srst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE
- row_count  in  ADDR_WIDTH+1  number of rows to drain; latched on accepted start
- sram_re_a  out  1  read enable to result SRAM
- sram_raddr_a  out  ADDR_WIDTH  read address
- sram_rdata_a  in  ARRAY_SIZE*OUTPUT_DATA_WIDTH  read data, valid the cycle after sram_re_a
- out_data  out  OUTPUT_DATA_WIDTH  current element
- out_valid  out  1  out_data is valid
- out_ready  in  1  host accepts the element when out_valid && out_ready
- out_last  out  1  high with the final element of the drain
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the drain completes

## Operation
- States: IDLE, READ, LOAD, SEND, DONE.
- IDLE:
  - start=1 latches count = min(row_count, MAX_ROWS) and clears row pointer and lane index.
  - If count==0, go to DONE; otherwise go to READ.
- READ (1 cycle): sram_re_a=1, sram_raddr_a=row pointer. Go to LOAD.
- LOAD (1 cycle):
  - Capture sram_rdata_a into the row register and set lane=0.
  - Go to SEND.
- SEND:
  - out_valid=1, out_data = row_reg[lane*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]. Lane 0 is the LSBs.
  - On handshake, lane increments.
  - On the handshake of lane ARRAY_SIZE-1: row pointer increments. If rows remain, go to READ; else go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- out_last = SEND && lane==ARRAY_SIZE-1 && row pointer==count-1.
- Data passes through bit-exact; no sign handling or rounding.
- start outside IDLE is ignored. row_count changes after latch are ignored.

## Timing
- Reset values (asynchronous, immediate on srst): state IDLE, and all of the following at 0: sram_re_a, sram_raddr_a, out_data, out_valid, out_last, busy, done, internal counters.
- srst mid-drain aborts immediately. No done pulse is issued; a fresh start is required.
- sram_raddr_a reads 0 in IDLE and holds its last value in the other non-READ states.
- Start accepted at cycle 0. Row 0 is read in cycle 1, loaded in cycle 2, and lane 0 is valid in cycle 3.
- With out_ready held high:
  - Row k lane j is presented at cycle 3 + k*(ARRAY_SIZE+2) + j.
  - done is high at cycle 3 + count*(ARRAY_SIZE+2) - 2, the cycle after the last handshake.
- Backpressure: while out_valid=1 && out_ready=0, out_data, out_valid and out_last hold stable; no valid retraction.
- count==0: busy in cycle 1 (DONE), done=1 in cycle 1, no SRAM read, no out_valid.
- row_count>MAX_ROWS is clamped to MAX_ROWS. The final address is MAX_ROWS-1 and never wraps.
- busy is high from cycle 1 through the DONE cycle inclusive. A start in the cycle after done is accepted.

## Test plan
- Reset values: assert srst mid-cycle with clk stopped -> all outputs 0 immediately; state IDLE after release.
- Single row: SRAM row0 = elements 1..8 in lanes 0..7, row_count=1, out_ready=1 -> addr 0 read at cycle 1; out_data 1..8 on cycles 3..10; out_last at cycle 10; done at cycle 11.
- Full drain: row r lane j = r*8+j, row_count=64, out_ready=1 -> 512 elements 0..511 in order; addresses 0..63 each read once; done at cycle 641; single out_last.
- Backpressure: row_count=2 with out_ready toggling pseudo-randomly -> sequence identical to the ready-high case; out_data stable during every stall; no element lost or duplicated.
- Edge counts: row_count=0 -> done at cycle 1 with no sram_re_a. row_count=100 -> exactly 64 rows drained.
- Abort and restart: srst during SEND of row 3 -> outputs clear and no done. New start with row_count=1 -> normal single-row response from address 0. start pulses while busy -> ignored.

Source files
------------

// File: rtl/sram_readback.sv
// sram_readback: drains rows of the result SRAM (bank A) and streams them to
// the host one element at a time, lane 0 (LSBs) first.
//
// Handshake: out_valid/out_ready. An element transfers on a rising edge where
// out_valid && out_ready. Once out_valid rises it stays high, and out_data and
// out_last stay stable, until that element has transferred.
module sram_readback #(
   parameter int ARRAY_SIZE        = 8,
   parameter int OUTPUT_DATA_WIDTH = 16,
   parameter int ADDR_WIDTH        = 6,
   parameter int MAX_ROWS          = 64
) (
   input  logic                                    clk,
   input  logic                                    srst,
   input  logic                                    start,
   input  logic [ADDR_WIDTH:0]                     row_count,
   output logic                                    sram_re_a,
   output logic [ADDR_WIDTH-1:0]                   sram_raddr_a,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
   output logic [OUTPUT_DATA_WIDTH-1:0]            out_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    done,
   output logic [2:0]                              state_dbg
);

   localparam int LANE_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam int CNT_W  = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]  MAX_ROWS_C = CNT_W'(MAX_ROWS);
   localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(ARRAY_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_LOAD = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                              state_q, state_d;
   logic [CNT_W-1:0]                    count_q;
   logic [CNT_W-1:0]                    row_ptr_q;
   logic [LANE_W-1:0]                   lane_q;
   logic [ADDR_WIDTH-1:0]               addr_q;
   logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] row_reg_q;

   logic             handshake;
   logic             last_lane;
   logic [CNT_W-1:0] row_count_clamped;
   logic [CNT_W-1:0] row_ptr_inc;

   assign handshake         = (state_q == S_SEND) && out_ready;
   assign last_lane         = (lane_q == LAST_LANE);
   assign row_count_clamped = (row_count > MAX_ROWS_C) ? MAX_ROWS_C : row_count;
   assign row_ptr_inc       = row_ptr_q + CNT_W'(1);

   // State register; srst aborts any drain immediately without a done pulse.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (row_count_clamped == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: state_d = S_LOAD;
         S_LOAD: state_d = S_SEND;
         S_SEND: begin
            if (handshake && last_lane) begin
               state_d = (row_ptr_inc < count_q) ? S_READ : S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: latch the row count, track row/lane position, capture SRAM rows.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         count_q   <= '0;
         row_ptr_q <= '0;
         lane_q    <= '0;
         addr_q    <= '0;
         row_reg_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  count_q   <= row_count_clamped;
                  row_ptr_q <= '0;
                  lane_q    <= '0;
               end
            end
            S_READ: addr_q <= row_ptr_q[ADDR_WIDTH-1:0];
            S_LOAD: begin
               row_reg_q <= sram_rdata_a;
               lane_q    <= '0;
            end
            S_SEND: begin
               if (handshake) begin
                  if (last_lane) begin
                     lane_q    <= '0;
                     row_ptr_q <= row_ptr_inc;
                  end else begin
                     lane_q <= lane_q + LANE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; the address holds its last value outside READ
   // except in IDLE, where it parks at zero.
   always_comb begin
      sram_re_a    = (state_q == S_READ);
      sram_raddr_a = addr_q;
      if (state_q == S_IDLE) begin
         sram_raddr_a = '0;
      end else if (state_q == S_READ) begin
         sram_raddr_a = row_ptr_q[ADDR_WIDTH-1:0];
      end
      out_valid = (state_q == S_SEND);
      out_data  = '0;
      if (state_q == S_SEND) begin
         out_data = row_reg_q[int'(lane_q)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
      end
      out_last  = (state_q == S_SEND) && last_lane &&
                  (row_ptr_q == (count_q - CNT_W'(1)));
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_sram_readback.sv
// Directed bench for sram_readback: a behavioural SRAM, an expected-element
// queue built from the SRAM contents, and cycle-accurate timing checks.
module tb_sram_readback;

   localparam int AS = 8;
   localparam int W  = 16;
   localparam int AW = 6;
   localparam int MR = 64;

   logic            clk = 1'b0;
   logic            clk_en = 1'b0;
   logic            srst;
   logic            start;
   logic [AW:0]     row_count;
   logic            sram_re_a;
   logic [AW-1:0]   sram_raddr_a;
   logic [AS*W-1:0] sram_rdata_a;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic            busy;
   logic            done;
   logic [2:0]      state_dbg;

   logic [AS*W-1:0] mem [MR];
   logic [W-1:0]    exp_q[$];

   int checks = 0;
   int errors = 0;

   sram_readback #(
      .ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(W), .ADDR_WIDTH(AW), .MAX_ROWS(MR)
   ) dut (
      .clk(clk), .srst(srst), .start(start), .row_count(row_count),
      .sram_re_a(sram_re_a), .sram_raddr_a(sram_raddr_a), .sram_rdata_a(sram_rdata_a),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // Clock/reset: clock can be held stopped via clk_en.
   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // Synchronous-read SRAM model: data valid the cycle after the read enable.
   always @(posedge clk) begin
      if (sram_re_a) sram_rdata_a <= mem[sram_raddr_a];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic init_mem(input int base);
      for (int r = 0; r < MR; r++)
         for (int j = 0; j < AS; j++)
            mem[r][j*W +: W] = W'(base + r*AS + j);
   endtask

   // Driver + scoreboard for one drain. rnd_ready toggles out_ready;
   // poke_start throws start/row_count noise while the drain runs.
   task automatic run_drain(input int rows_req, input bit rnd_ready,
                            input bit poke_start, input string tag);
      int rows, cyc, done_cyc, hs, nread, bad;
      int reads [MR];
      logic [W-1:0] prev_data, e;
      logic prev_stall, prev_last;
      rows = (rows_req > MR) ? MR : rows_req;
      exp_q.delete();
      for (int r = 0; r < rows; r++)
         for (int j = 0; j < AS; j++) exp_q.push_back(mem[r][j*W +: W]);
      for (int i = 0; i < MR; i++) reads[i] = 0;
      start = 1'b1;
      row_count = (AW+1)'(rows_req);
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1; done_cyc = -1; hs = 0; nread = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      while (done_cyc < 0 && cyc < 2000) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_start) begin
            start = 1'($urandom_range(0, 1));
            row_count = (AW+1)'($urandom_range(0, 127));
         end
         if (cyc == 1) check({tag, " busy_c1"}, busy, 1);
         if (prev_stall) begin
            check({tag, " stall_valid"}, out_valid, 1);
            check({tag, " stall_data"}, out_data, prev_data);
            check({tag, " stall_last"}, out_last, prev_last);
         end
         if (sram_re_a) begin
            check({tag, " raddr"}, sram_raddr_a, nread);
            if (nread == 0) check({tag, " first_read_cyc"}, cyc, 1);
            reads[sram_raddr_a]++;
            nread++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, " extra_elem"}, hs, rows*AS);
            end else begin
               e = exp_q.pop_front();
               check({tag, " data"}, out_data, e);
               check({tag, " last"}, out_last, (exp_q.size() == 0));
               if (!rnd_ready)
                  check({tag, " elem_cyc"}, cyc, 3 + (hs/AS)*(AS+2) + hs%AS);
            end
            hs++;
         end
         if (done) done_cyc = cyc;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (done_cyc < 0) begin
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) check({tag, " done_timeout"}, done, 1);
      else if (!rnd_ready)
         check({tag, " done_cyc"}, done_cyc, (rows == 0) ? 1 : 3 + rows*(AS+2) - 2);
      check({tag, " elem_count"}, hs, rows*AS);
      check({tag, " read_count"}, nread, rows);
      bad = 0;
      for (int i = 0; i < MR; i++)
         if (reads[i] != ((i < rows) ? 1 : 0)) bad++;
      check({tag, " read_map"}, bad, 0);
      tick();
      check({tag, " idle_busy"}, busy, 0);
      check({tag, " idle_done"}, done, 0);
   endtask

   initial begin
      int seen;
      srst = 1'b0; start = 1'b0; row_count = '0; out_ready = 1'b0;
      sram_rdata_a = '0;
      init_mem(0);

      // Reset with the clock stopped: outputs must clear immediately.
      #3 srst = 1'b1;
      #1;
      check("rst sram_re_a", sram_re_a, 0);
      check("rst sram_raddr_a", sram_raddr_a, 0);
      check("rst out_data", out_data, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_last", out_last, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst state", state_dbg, 0);
      clk_en = 1'b1;
      repeat (2) tick();
      srst = 1'b0;
      tick();
      check("post_rst state", state_dbg, 0);
      check("post_rst busy", busy, 0);

      // Single row, elements 1..8.
      init_mem(1);
      run_drain(1, 1'b0, 1'b0, "single");

      // Full drain, elements 0..511; next drains start the cycle after done+1.
      init_mem(0);
      run_drain(64, 1'b0, 1'b0, "full");
      run_drain(2, 1'b1, 1'b0, "bp");
      run_drain(0, 1'b0, 1'b0, "zero");
      run_drain(100, 1'b0, 1'b0, "clamp");

      // Abort during SEND of row 3 (lane 2 at cycle 35).
      start = 1'b1; row_count = 7'd5;
      tick();
      start = 1'b0;
      repeat (34) tick();
      check("abort pre_state", state_dbg, 3);
      check("abort pre_data", out_data, 3*AS + 2);
      #2 srst = 1'b1;
      #1;
      check("abort out_valid", out_valid, 0);
      check("abort out_data", out_data, 0);
      check("abort out_last", out_last, 0);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sram_re_a", sram_re_a, 0);
      check("abort state", state_dbg, 0);
      tick();
      srst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (done || out_valid || busy) seen++;
         tick();
      end
      check("abort quiet", seen, 0);

      // Restart with start/row_count noise while busy.
      run_drain(1, 1'b0, 1'b1, "restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
